// File: rtl/multicore_pkg.sv
// Shared constants and FSM encoding for the multicore result path.
// Also supplies the default core count and width used by the MultiCore top.
package multicore_pkg;

  localparam int NUM_CORES_DEF = 61;
  localparam int DATA_W_DEF    = 32;
  localparam int IDX_W_DEF     = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REDUCE  = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/result_compare.sv
// Unsigned compare for the reducer scan.
// replace=1 when cand strictly beats best (min or max mode).
module result_compare #(
  parameter int DATA_W   = 32,
  parameter int MODE_MAX = 0
) (
  input  logic [DATA_W-1:0] cand,
  input  logic [DATA_W-1:0] best,
  output logic              replace
);

  assign replace = (MODE_MAX != 0) ? (cand > best)
                                   : (cand < best);

endmodule

// File: rtl/multicore_result_reducer.sv
// Latches each core's final v0 on completion, then min/max-scans
// the latched values one core per cycle and hands out the winner.
module multicore_result_reducer
  import multicore_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int IDX_W     = IDX_W_DEF,
  parameter int MODE_MAX  = 0
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        Start,
  input  logic [NUM_CORES-1:0]        Core_Done,
  input  logic [NUM_CORES*DATA_W-1:0] Core_V0,
  output logic [NUM_CORES-1:0]        Captured,
  output logic                        Busy,
  output logic                        Result_Valid,
  input  logic                        Result_Ready,
  output logic [DATA_W-1:0]           Best_Value,
  output logic [IDX_W-1:0]            Best_Index
);

  localparam logic [IDX_W-1:0] K_LAST =
    IDX_W'(NUM_CORES - 1);

  state_t               state;
  logic [DATA_W-1:0]    vals [NUM_CORES];
  logic [IDX_W-1:0]     k;
  logic [DATA_W-1:0]    cur_best;
  logic [IDX_W-1:0]     cur_idx;
  logic [DATA_W-1:0]    k_val;
  logic                 replace;
  logic                 take;
  logic [DATA_W-1:0]    fin_val;
  logic [IDX_W-1:0]     fin_idx;
  logic [NUM_CORES-1:0] cap_new;
  logic                 cap_en;

  assign cap_new = Core_Done & ~Captured;
  assign cap_en  = (state == COLLECT) && !Start;

  always_comb begin
    k_val = '0;
    for (int i = 0; i < NUM_CORES; i++)
      if (k == IDX_W'(i)) k_val = vals[i];
  end

  result_compare #(
    .DATA_W   (DATA_W),
    .MODE_MAX (MODE_MAX)
  ) u_cmp (
    .cand    (k_val),
    .best    (cur_best),
    .replace (replace)
  );

  // first scan step seeds the running best unconditionally
  assign take    = (k == '0) || replace;
  assign fin_val = take ? k_val : cur_best;
  assign fin_idx = take ? k : cur_idx;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_CORES; i++)
        vals[i] <= '0;
    end else if (cap_en) begin
      for (int i = 0; i < NUM_CORES; i++)
        if (cap_new[i])
          vals[i] <= Core_V0[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      Captured     <= '0;
      Busy         <= 1'b0;
      Result_Valid <= 1'b0;
      Best_Value   <= '0;
      Best_Index   <= '0;
      k            <= '0;
      cur_best     <= '0;
      cur_idx      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Start) begin
            state    <= COLLECT;
            Captured <= '0;
            Busy     <= 1'b1;
          end
        end
        COLLECT: begin
          if (Start) begin
            Captured <= '0;
          end else if (&Captured) begin
            state <= REDUCE;
            k     <= '0;
          end else begin
            Captured <= Captured | cap_new;
          end
        end
        REDUCE: begin
          if (Start) begin
            state    <= COLLECT;
            Captured <= '0;
          end else begin
            cur_best <= fin_val;
            cur_idx  <= fin_idx;
            k        <= k + 1'b1;
            if (k == K_LAST) begin
              state        <= DONE;
              Busy         <= 1'b0;
              Result_Valid <= 1'b1;
              Best_Value   <= fin_val;
              Best_Index   <= fin_idx;
            end
          end
        end
        DONE: begin
          if (Result_Ready) begin
            Result_Valid <= 1'b0;
            if (Start) begin
              state    <= COLLECT;
              Captured <= '0;
              Busy     <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicore_result_reducer.sv
// Bench for multicore_result_reducer: min and max instances, 4 cores,
// checked every cycle against a round-level reference model.
module tb_multicore_result_reducer;

  localparam int NC = 4;
  localparam int DW = 32;
  localparam int IW = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           ready = 1'b0;
  logic [NC-1:0]  done = '0;
  logic [NC*DW-1:0] v0 = '0;

  logic [NC-1:0]  cap0, cap1;
  logic           busy0, busy1;
  logic           val0, val1;
  logic [DW-1:0]  bv0, bv1;
  logic [IW-1:0]  bi0, bi1;

  int ntests = 0;
  int nfail  = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  multicore_result_reducer #(
    .NUM_CORES(NC), .DATA_W(DW), .IDX_W(IW), .MODE_MAX(0)
  ) dut_min (
    .Clk(clk), .Reset(rst_n), .Start(start),
    .Core_Done(done), .Core_V0(v0),
    .Captured(cap0), .Busy(busy0),
    .Result_Valid(val0), .Result_Ready(ready),
    .Best_Value(bv0), .Best_Index(bi0)
  );

  multicore_result_reducer #(
    .NUM_CORES(NC), .DATA_W(DW), .IDX_W(IW), .MODE_MAX(1)
  ) dut_max (
    .Clk(clk), .Reset(rst_n), .Start(start),
    .Core_Done(done), .Core_V0(v0),
    .Captured(cap1), .Busy(busy1),
    .Result_Valid(val1), .Result_Ready(ready),
    .Best_Value(bv1), .Best_Index(bi1)
  );

  // reference model: round phase, capture mask, latched values,
  // and the reduced answer for min (0) and max (1)
  int          mst = 0;
  int          mcnt = 0;
  logic [NC-1:0] mcap = '0;
  logic        mvalid = 1'b0;
  logic [DW-1:0] mval [NC];
  logic [DW-1:0] mbv [2];
  logic [IW-1:0] mbi [2];

  initial begin
    for (int i = 0; i < NC; i++) mval[i] = '0;
    for (int m = 0; m < 2; m++) begin
      mbv[m] = '0;
      mbi[m] = '0;
    end
  end

  task automatic model_reduce();
    for (int m = 0; m < 2; m++) begin
      logic [DW-1:0] b;
      int bi;
      b = mval[0];
      bi = 0;
      for (int i = 1; i < NC; i++)
        if (m == 0 ? (mval[i] < b) : (mval[i] > b)) begin
          b = mval[i];
          bi = i;
        end
      mbv[m] = b;
      mbi[m] = IW'(bi);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mst = 0; mcnt = 0; mcap = '0; mvalid = 1'b0;
      for (int i = 0; i < NC; i++) mval[i] = '0;
      for (int m = 0; m < 2; m++) begin
        mbv[m] = '0;
        mbi[m] = '0;
      end
    end else begin
      case (mst)
        0: if (start) begin mst = 1; mcap = '0; end
        1: begin
          if (start) mcap = '0;
          else if (&mcap) begin mst = 2; mcnt = 0; end
          else
            for (int i = 0; i < NC; i++)
              if (done[i] && !mcap[i]) begin
                mval[i] = v0[i*DW +: DW];
                mcap[i] = 1'b1;
              end
        end
        2: begin
          if (start) begin mst = 1; mcap = '0; end
          else begin
            mcnt++;
            if (mcnt == NC) begin
              model_reduce();
              mst = 3;
              mvalid = 1'b1;
            end
          end
        end
        default: begin
          if (ready) begin
            mvalid = 1'b0;
            if (start) begin mst = 1; mcap = '0; end
            else mst = 0;
          end
        end
      endcase
    end
  end

  task automatic cmp(input string nm, input logic [NC-1:0] c,
                     input logic b, input logic v,
                     input logic [DW-1:0] bv,
                     input logic [IW-1:0] bi, input int m);
    logic eb;
    eb = (mst == 1 || mst == 2);
    ntests++;
    if ({c, b, v, bv, bi} !== {mcap, eb, mvalid, mbv[m], mbi[m]}) begin
      nfail++;
      $display("FAIL %s t=%0t got cap=%h busy=%b valid=%b val=%0d idx=%0d want cap=%h busy=%b valid=%b val=%0d idx=%0d",
               nm, $time, c, b, v, bv, bi,
               mcap, eb, mvalid, mbv[m], mbi[m]);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model_min", cap0, busy0, val0, bv0, bi0, 0);
      cmp("model_max", cap1, busy1, val1, bv1, bi1, 1);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_vals(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] c, input logic [DW-1:0] d);
    v0 = {d, c, b, a};
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string nm, input int lim);
    int n;
    n = 0;
    while (!val0 && n < lim) begin
      cyc(1);
      n++;
    end
    chk(nm, 64'(val0), 64'd1);
  endtask

  task automatic accept();
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
  endtask

  initial begin
    // reset held with random inputs
    start = 1'b1;
    ready = 1'b1;
    done = 4'($urandom);
    v0 = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    #1 chk_en = 1'b1;
    cyc(3);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_valid", 64'(val1), 64'd0);
    chk("rst_value", 64'(bv0), 64'd0);
    chk("rst_cap", 64'(cap1), 64'd0);
    start = 1'b0; ready = 1'b0; done = '0; v0 = '0;
    #2 rst_n = 1'b1;
    cyc(2);

    // basic min round, latency from capture edge
    set_vals(40, 7, 19, 7);
    pulse_start();
    cyc(1);
    done = 4'b1111;
    cyc(1);
    chk("cap_all", 64'(cap0), 64'hf);
    cyc(4);
    chk("lat_not_yet", 64'(val0), 64'd0);
    cyc(1);
    chk("lat_valid", 64'(val0), 64'd1);
    chk("min_val", 64'(bv0), 64'd7);
    chk("min_idx", 64'(bi0), 64'd1);
    chk("max_val", 64'(bv1), 64'd40);
    accept();
    chk("accepted", 64'(val0), 64'd0);
    done = '0;
    cyc(1);

    // staggered completion, v0 changes after capture
    set_vals(20, 30, 25, 5);
    pulse_start();
    done = 4'b1000;
    cyc(1);
    set_vals(20, 30, 25, 0);
    chk("stag_cap3", 64'(cap0), 64'h8);
    cyc(2);
    done = 4'b1100;
    cyc(1);
    chk("stag_cap2", 64'(cap0), 64'hc);
    done = 4'b0110;
    cyc(1);
    chk("stag_cap1", 64'(cap0), 64'he);
    done = '0;
    cyc(4);
    done = 4'b0001;
    wait_valid("stag_wait", 20);
    chk("stag_min_val", 64'(bv0), 64'd5);
    chk("stag_min_idx", 64'(bi0), 64'd3);
    chk("stag_max_idx", 64'(bi1), 64'd1);
    accept();
    done = '0;
    cyc(1);

    // max tie keeps lowest index; result held while not ready
    set_vals(5, 9, 9, 2);
    pulse_start();
    done = 4'b1111;
    wait_valid("hold_wait", 20);
    cyc(10);
    pulse_start();
    cyc(9);
    chk("hold_valid", 64'(val1), 64'd1);
    chk("hold_max_val", 64'(bv1), 64'd9);
    chk("hold_max_idx", 64'(bi1), 64'd1);
    chk("hold_min_idx", 64'(bi0), 64'd3);

    // accept and restart on the same edge
    ready = 1'b1; start = 1'b1; done = '0;
    cyc(1);
    ready = 1'b0; start = 1'b0;
    chk("restart_busy", 64'(busy0), 64'd1);
    chk("restart_valid", 64'(val0), 64'd0);

    // abort mid-collect after two captures
    set_vals(1, 2, 8, 8);
    done = 4'b0011;
    cyc(1);
    chk("abort_pre", 64'(cap0), 64'h3);
    pulse_start();
    chk("abort_cap", 64'(cap0), 64'h0);
    set_vals(3, 3, 3, 3);
    done = 4'b1111;
    wait_valid("abort_wait", 20);
    chk("abort_min_idx", 64'(bi0), 64'd0);
    chk("abort_max_idx", 64'(bi1), 64'd0);
    chk("abort_val", 64'(bv0), 64'd3);
    accept();
    done = '0;
    cyc(1);

    // reset mid-reduce
    set_vals(11, 12, 13, 14);
    start = 1'b1; done = 4'b1111;
    cyc(1);
    start = 1'b0;
    cyc(4);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy0), 64'd0);
    chk("mid_rst_cap", 64'(cap0), 64'd0);
    cyc(2);
    done = '0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk("no_valid", 64'(val0 | val1), 64'd0);
    end
    set_vals(100, 50, 50, 75);
    pulse_start();
    done = 4'b1111;
    wait_valid("post_rst_wait", 20);
    chk("post_min_idx", 64'(bi0), 64'd1);
    chk("post_max_val", 64'(bv1), 64'd100);
    accept();
    done = '0;

    // randomized traffic
    for (int t = 0; t < 600; t++) begin
      start = ($urandom_range(0, 29) == 0);
      ready = 1'($urandom);
      done  = 4'($urandom);
      for (int i = 0; i < NC; i++)
        v0[i*DW +: DW] = ($urandom_range(0, 3) == 0) ?
                         $urandom : DW'($urandom_range(0, 7));
      cyc(1);
    end
    start = 1'b0;
    ready = 1'b1;
    cyc(20);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
